// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding select, load-use hazard stall FSM and
// optional multi-cycle writer scoreboard (enabled by defining FWD_SCOREBOARD_EN).
// Outputs are combinational from inputs and registered state; all forced low in reset.

// Per-source forwarding select: youngest enabled stage writing the source register.
module fwd_src_sel #(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int SW      = 2
) (
  input  logic [REG_AW-1:0]         i_rs,
  input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  output logic [SW-1:0]             o_sel
);

  // Scan oldest to youngest so the youngest match overwrites; x0 never forwards.
  always_comb begin
    o_sel = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_we[i] && (i_rs != '0) && (i_fwd_rd[i*REG_AW +: REG_AW] == i_rs))
        o_sel = SW'(i + 1);
    end
  end

endmodule

module fwd_hazard_unit #(
  parameter int  REG_AW  = 5,
  parameter int  NUM_SRC = 2,
  parameter int  NUM_FWD = 2,
  parameter int  LD_LAT  = 1,
  localparam int SW      = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      mc_issue,
  input  logic [REG_AW-1:0]         mc_issue_rd,
  input  logic                      mc_done,
  input  logic [REG_AW-1:0]         mc_done_rd,
  output logic                      stall,
  output logic                      flush_ex,
  output logic                      sb_busy
);

  // Counter holds the remaining LD_WAIT cycles; at least 2 bits wide.
  localparam int CW = ($clog2(LD_LAT + 1) > 2) ? $clog2(LD_LAT + 1) : 2;

  typedef enum logic {S_IDLE, S_LD_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [NUM_SRC*SW-1:0] w_sel;
  logic                w_ld_hit, w_ld_detect, w_ld_stall, w_sb_stall, w_sb_busy;

  // ---------------- forwarding ----------------
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_sel #(
      .REG_AW (REG_AW),
      .NUM_FWD(NUM_FWD),
      .SW     (SW)
    ) u_sel (
      .i_rs    (ex_rs[s*REG_AW +: REG_AW]),
      .i_fwd_rd(fwd_rd),
      .i_fwd_we(fwd_we),
      .o_sel   (w_sel[s*SW +: SW])
    );
  end

  // ---------------- load-use detect ----------------
  // Any used IF/ID source reading the register the ID/EX load will write.
  always_comb begin
    w_ld_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used[s] && (id_rs[s*REG_AW +: REG_AW] == ex_rd))
        w_ld_hit = 1'b1;
    end
  end

  assign w_ld_detect = ex_memread && (ex_rd != '0) && w_ld_hit;

  // FSM state and remaining-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Detection stalls the first cycle; LD_WAIT covers the remaining LD_LAT-1 cycles.
  // While waiting, ID/EX holds a bubble so detection is not re-evaluated.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld_stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ld_detect) begin
          w_ld_stall = 1'b1;
          if (LD_LAT > 1) begin
            w_state_nxt = S_LD_WAIT;
            w_cnt_nxt   = CW'(LD_LAT - 1);
          end
        end
      end
      S_LD_WAIT: begin
        w_ld_stall = 1'b1;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1))
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------- multi-cycle scoreboard ----------------
`ifdef FWD_SCOREBOARD_EN
  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] r_pending, w_pending_nxt;

  // Done clears first, then issue sets, so a same-cycle issue/done leaves the bit set.
  always_comb begin
    w_pending_nxt = r_pending;
    if (mc_done)
      w_pending_nxt[mc_done_rd] = 1'b0;
    if (mc_issue && (mc_issue_rd != '0))
      w_pending_nxt[mc_issue_rd] = 1'b1;
  end

  // Pending-write bits, one per architectural register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  // Stall on registered bits only; the result arrives by WB forwarding after the clear.
  always_comb begin
    w_sb_stall = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used[s] && r_pending[id_rs[s*REG_AW +: REG_AW]])
        w_sb_stall = 1'b1;
    end
  end

  assign w_sb_busy = |r_pending;
`else
  logic w_unused_mc;
  assign w_unused_mc = ^{mc_issue, mc_issue_rd, mc_done, mc_done_rd};
  assign w_sb_stall  = 1'b0;
  assign w_sb_busy   = 1'b0;
`endif

  // ---------------- outputs (forced low in reset) ----------------
  assign stall    = rst_n & (w_ld_stall | w_sb_stall);
  assign flush_ex = stall;
  assign sb_busy  = rst_n & w_sb_busy;
  assign fwd_sel  = rst_n ? w_sel : '0;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance (NUM_FWD=2, LD_LAT=1) and a
// NUM_FWD=3, LD_LAT=3 instance; expectations queued at drive, compared at negedge.
module tb_fwd_hazard_unit;

`ifdef FWD_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  typedef struct {
    logic [3:0] sel;
    logic       stall;
    logic       flush;
    logic       busy;
  } exp_t;

  logic clk, rst_n;

  // instance a: defaults
  logic [9:0] ex_rs_a, id_rs_a, fwd_rd_a;
  logic [1:0] fwd_we_a, id_rs_used_a;
  logic [3:0] fwd_sel_a;
  logic       ex_memread_a, mc_issue_a, mc_done_a;
  logic [4:0] ex_rd_a, mc_issue_rd_a, mc_done_rd_a;
  logic       stall_a, flush_a, busy_a;

  // instance b: NUM_FWD=3, LD_LAT=3
  logic [9:0]  ex_rs_b, id_rs_b;
  logic [14:0] fwd_rd_b;
  logic [2:0]  fwd_we_b;
  logic [1:0]  id_rs_used_b;
  logic [3:0]  fwd_sel_b;
  logic        ex_memread_b, mc_issue_b, mc_done_b;
  logic [4:0]  ex_rd_b, mc_issue_rd_b, mc_done_rd_b;
  logic        stall_b, flush_b, busy_b;

  exp_t qa[$], qb[$];
  int checks = 0, failures = 0;

  fwd_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs_a), .fwd_rd(fwd_rd_a), .fwd_we(fwd_we_a),
    .fwd_sel(fwd_sel_a), .id_rs(id_rs_a), .id_rs_used(id_rs_used_a),
    .ex_memread(ex_memread_a), .ex_rd(ex_rd_a), .mc_issue(mc_issue_a),
    .mc_issue_rd(mc_issue_rd_a), .mc_done(mc_done_a), .mc_done_rd(mc_done_rd_a),
    .stall(stall_a), .flush_ex(flush_a), .sb_busy(busy_a)
  );

  fwd_hazard_unit #(.NUM_FWD(3), .LD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs_b), .fwd_rd(fwd_rd_b), .fwd_we(fwd_we_b),
    .fwd_sel(fwd_sel_b), .id_rs(id_rs_b), .id_rs_used(id_rs_used_b),
    .ex_memread(ex_memread_b), .ex_rd(ex_rd_b), .mc_issue(mc_issue_b),
    .mc_issue_rd(mc_issue_rd_b), .mc_done(mc_done_b), .mc_done_rd(mc_done_rd_b),
    .stall(stall_b), .flush_ex(flush_b), .sb_busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ex_rs_a = '0; id_rs_a = '0; fwd_rd_a = '0; fwd_we_a = '0; id_rs_used_a = '0;
    ex_memread_a = 0; ex_rd_a = '0; mc_issue_a = 0; mc_done_a = 0;
    mc_issue_rd_a = '0; mc_done_rd_a = '0;
    ex_rs_b = '0; id_rs_b = '0; fwd_rd_b = '0; fwd_we_b = '0; id_rs_used_b = '0;
    ex_memread_b = 0; ex_rd_b = '0; mc_issue_b = 0; mc_done_b = 0;
    mc_issue_rd_b = '0; mc_done_rd_b = '0;
  endtask

  // Outputs forced low while reset is held, even with hazards and matches presented.
  task automatic test_reset();
    exp_t e;
    @(posedge clk); #1;
    ex_rs_a = {5'd3, 5'd3}; fwd_rd_a = {5'd3, 5'd3}; fwd_we_a = 2'b11;
    ex_memread_a = 1; ex_rd_a = 5'd5; id_rs_a = {5'd0, 5'd5}; id_rs_used_a = 2'b01;
    ex_rs_b = {5'd1, 5'd1}; fwd_rd_b = {5'd1, 5'd1, 5'd1}; fwd_we_b = 3'b111;
    ex_memread_b = 1; ex_rd_b = 5'd5; id_rs_b = {5'd0, 5'd5}; id_rs_used_b = 2'b01;
    qa.push_back('{4'b0000, 1'b0, 1'b0, 1'b0});
    qb.push_back('{4'b0000, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    e = qa.pop_front(); checks++;
    if ({fwd_sel_a, stall_a, flush_a, busy_a} !== {e.sel, e.stall, e.flush, e.busy}) begin
      failures++;
      $display("FAIL reset_a got sel=%b st=%b fl=%b bz=%b want sel=%b st=%b fl=%b bz=%b",
               fwd_sel_a, stall_a, flush_a, busy_a, e.sel, e.stall, e.flush, e.busy);
    end
    e = qb.pop_front(); checks++;
    if ({fwd_sel_b, stall_b, flush_b, busy_b} !== {e.sel, e.stall, e.flush, e.busy}) begin
      failures++;
      $display("FAIL reset_b got sel=%b st=%b fl=%b bz=%b want sel=%b st=%b fl=%b bz=%b",
               fwd_sel_b, stall_b, flush_b, busy_b, e.sel, e.stall, e.flush, e.busy);
    end
    idle_inputs();
    rst_n = 1;
  endtask

  // Forwarding select on both instances in parallel.
  task automatic test_forwarding();
    logic [9:0]  rs_a[5], rd_a[5], rs_b[5];
    logic [1:0]  we_a[5];
    logic [14:0] rd_b[5];
    logic [2:0]  we_b[5];
    logic [3:0]  xa[5], xb[5];
    exp_t e;
    // a: {s1,s0} sources, {stage1,stage0} rds
    rs_a[0] = {5'd3, 5'd3}; rd_a[0] = {5'd3, 5'd3}; we_a[0] = 2'b11; xa[0] = {2'd1, 2'd1};
    rs_a[1] = {5'd3, 5'd3}; rd_a[1] = {5'd3, 5'd3}; we_a[1] = 2'b10; xa[1] = {2'd2, 2'd2};
    rs_a[2] = {5'd3, 5'd0}; rd_a[2] = {5'd3, 5'd3}; we_a[2] = 2'b11; xa[2] = {2'd1, 2'd0};
    rs_a[3] = {5'd4, 5'd3}; rd_a[3] = {5'd4, 5'd3}; we_a[3] = 2'b11; xa[3] = {2'd2, 2'd1};
    rs_a[4] = {5'd4, 5'd3}; rd_a[4] = {5'd3, 5'd4}; we_a[4] = 2'b11; xa[4] = {2'd1, 2'd2};
    // b: {stage2,stage1,stage0} rds
    rs_b[0] = {5'd2, 5'd9}; rd_b[0] = {5'd9, 5'd2, 5'd1}; we_b[0] = 3'b111; xb[0] = {2'd2, 2'd3};
    rs_b[1] = {5'd0, 5'd0}; rd_b[1] = {5'd0, 5'd0, 5'd0}; we_b[1] = 3'b111; xb[1] = {2'd0, 2'd0};
    rs_b[2] = {5'd6, 5'd0}; rd_b[2] = {5'd6, 5'd6, 5'd0}; we_b[2] = 3'b111; xb[2] = {2'd2, 2'd0};
    rs_b[3] = {5'd6, 5'd0}; rd_b[3] = {5'd6, 5'd0, 5'd0}; we_b[3] = 3'b011; xb[3] = {2'd0, 2'd0};
    rs_b[4] = {5'd9, 5'd9}; rd_b[4] = {5'd9, 5'd9, 5'd9}; we_b[4] = 3'b100; xb[4] = {2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ex_rs_a = rs_a[i]; fwd_rd_a = rd_a[i]; fwd_we_a = we_a[i];
      ex_rs_b = rs_b[i]; fwd_rd_b = rd_b[i]; fwd_we_b = we_b[i];
      qa.push_back('{xa[i], 1'b0, 1'b0, 1'b0});
      qb.push_back('{xb[i], 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      e = qa.pop_front(); checks++;
      if (fwd_sel_a !== e.sel) begin
        failures++;
        $display("FAIL fwd_a[%0d] got sel=%b want sel=%b", i, fwd_sel_a, e.sel);
      end
      e = qb.pop_front(); checks++;
      if (fwd_sel_b !== e.sel) begin
        failures++;
        $display("FAIL fwd_b[%0d] got sel=%b want sel=%b", i, fwd_sel_b, e.sel);
      end
    end
    idle_inputs();
  endtask

  // LD_LAT=1: single-cycle stall, gated by id_rs_used and ex_rd!=0.
  task automatic test_load_use_lat1();
    logic       mr[6], ex[6];
    logic [4:0] rd[6];
    logic [9:0] ir[6];
    logic [1:0] us[6];
    exp_t e;
    mr[0] = 1; rd[0] = 5'd5; ir[0] = {5'd0, 5'd5}; us[0] = 2'b01; ex[0] = 1;
    mr[1] = 0; rd[1] = 5'd5; ir[1] = {5'd0, 5'd5}; us[1] = 2'b01; ex[1] = 0;
    mr[2] = 1; rd[2] = 5'd5; ir[2] = {5'd5, 5'd0}; us[2] = 2'b01; ex[2] = 0;
    mr[3] = 1; rd[3] = 5'd5; ir[3] = {5'd5, 5'd0}; us[3] = 2'b10; ex[3] = 1;
    mr[4] = 0; rd[4] = 5'd5; ir[4] = {5'd5, 5'd0}; us[4] = 2'b10; ex[4] = 0;
    mr[5] = 1; rd[5] = 5'd0; ir[5] = {5'd0, 5'd0}; us[5] = 2'b11; ex[5] = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ex_memread_a = mr[i]; ex_rd_a = rd[i]; id_rs_a = ir[i]; id_rs_used_a = us[i];
      qa.push_back('{4'b0000, ex[i], ex[i], 1'b0});
      @(negedge clk);
      e = qa.pop_front(); checks++;
      if ({stall_a, flush_a, busy_a} !== {e.stall, e.flush, e.busy}) begin
        failures++;
        $display("FAIL ld1[%0d] got st=%b fl=%b bz=%b want st=%b fl=%b bz=%b",
                 i, stall_a, flush_a, busy_a, e.stall, e.flush, e.busy);
      end
    end
    idle_inputs();
  endtask

  // LD_LAT=3 on instance b, driven by a per-cycle memread table.
  task automatic run_ld3(input string nm, input int n, input logic [15:0] mr, input logic [15:0] ex);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ex_memread_b = mr[i]; ex_rd_b = 5'd5; id_rs_b = {5'd0, 5'd5}; id_rs_used_b = 2'b01;
      qb.push_back('{4'b0000, ex[i], ex[i], 1'b0});
      @(negedge clk);
      e = qb.pop_front(); checks++;
      if ({stall_b, flush_b} !== {e.stall, e.flush}) begin
        failures++;
        $display("FAIL %s[%0d] got st=%b fl=%b want st=%b fl=%b",
                 nm, i, stall_b, flush_b, e.stall, e.flush);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_use_lat3();
    run_ld3("ld3", 4, 16'b0001, 16'b0111);
  endtask

  // Second load-use right after the first wait ends: stall continues for another 3.
  task automatic test_back_to_back();
    run_ld3("b2b", 7, 16'b000_1111, 16'b011_1111);
  endtask

  // Reset in the second stall cycle drops stall at once and returns the FSM to IDLE.
  task automatic test_reset_mid_wait();
    exp_t e;
    logic [1:0] ex;
    ex = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      ex_memread_b = (i == 0); ex_rd_b = 5'd5; id_rs_b = {5'd0, 5'd5}; id_rs_used_b = 2'b01;
      if (i == 1) rst_n = 0;
      qb.push_back('{4'b0000, ex[i] & (i == 0), ex[i] & (i == 0), 1'b0});
      @(negedge clk);
      e = qb.pop_front(); checks++;
      if ({stall_b, flush_b} !== {e.stall, e.flush}) begin
        failures++;
        $display("FAIL rstmid[%0d] got st=%b fl=%b want st=%b fl=%b",
                 i, stall_b, flush_b, e.stall, e.flush);
      end
    end
    rst_n = 1;
    @(posedge clk); #1;
    ex_memread_b = 0;
    qb.push_back('{4'b0000, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    e = qb.pop_front(); checks++;
    if ({stall_b, flush_b} !== {e.stall, e.flush}) begin
      failures++;
      $display("FAIL rstmid_after got st=%b fl=%b want st=%b fl=%b",
               stall_b, flush_b, e.stall, e.flush);
    end
    idle_inputs();
  endtask

  // Scoreboard on instance a; expected stall/busy are zero when the feature is compiled out.
  task automatic test_scoreboard();
    logic       iss[13], dn[13], use0[13], xs[13], xb[13];
    logic [4:0] ird[13];
    exp_t e;
    //            issue       rd          done       use0         stall        busy
    iss[0]  = 1; ird[0]  = 7; dn[0]  = 0; use0[0]  = 0; xs[0]  = 0;  xb[0]  = 0;
    iss[1]  = 0; ird[1]  = 7; dn[1]  = 0; use0[1]  = 1; xs[1]  = SB; xb[1]  = SB;
    iss[2]  = 0; ird[2]  = 7; dn[2]  = 1; use0[2]  = 1; xs[2]  = SB; xb[2]  = SB;
    iss[3]  = 0; ird[3]  = 7; dn[3]  = 0; use0[3]  = 1; xs[3]  = 0;  xb[3]  = 0;
    iss[4]  = 1; ird[4]  = 7; dn[4]  = 1; use0[4]  = 0; xs[4]  = 0;  xb[4]  = 0;
    iss[5]  = 0; ird[5]  = 7; dn[5]  = 0; use0[5]  = 1; xs[5]  = SB; xb[5]  = SB;
    iss[6]  = 0; ird[6]  = 7; dn[6]  = 1; use0[6]  = 1; xs[6]  = SB; xb[6]  = SB;
    iss[7]  = 0; ird[7]  = 7; dn[7]  = 0; use0[7]  = 1; xs[7]  = 0;  xb[7]  = 0;
    iss[8]  = 1; ird[8]  = 0; dn[8]  = 0; use0[8]  = 0; xs[8]  = 0;  xb[8]  = 0;
    iss[9]  = 1; ird[9]  = 7; dn[9]  = 0; use0[9]  = 0; xs[9]  = 0;  xb[9]  = 0;
    iss[10] = 1; ird[10] = 7; dn[10] = 0; use0[10] = 0; xs[10] = 0;  xb[10] = SB;
    iss[11] = 0; ird[11] = 7; dn[11] = 1; use0[11] = 1; xs[11] = SB; xb[11] = SB;
    iss[12] = 0; ird[12] = 7; dn[12] = 0; use0[12] = 1; xs[12] = 0;  xb[12] = 0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      mc_issue_a = iss[i]; mc_issue_rd_a = ird[i];
      mc_done_a = dn[i]; mc_done_rd_a = 5'd7;
      id_rs_a = {5'd0, 5'd7}; id_rs_used_a = {1'b0, use0[i]};
      qa.push_back('{4'b0000, xs[i], xs[i], xb[i]});
      @(negedge clk);
      e = qa.pop_front(); checks++;
      if ({stall_a, flush_a, busy_a} !== {e.stall, e.flush, e.busy}) begin
        failures++;
        $display("FAIL sb[%0d] got st=%b fl=%b bz=%b want st=%b fl=%b bz=%b",
                 i, stall_a, flush_a, busy_a, e.stall, e.flush, e.busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use_lat1();
    test_load_use_lat3();
    test_back_to_back();
    test_reset_mid_wait();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
